// File: rtl/secded_mem_decoder.sv
// Memory-walking Hamming SECDED decoder.
// Reads NUM_WORDS 16-bit codewords (low byte first) from a byte-wide
// synchronous memory at SRC_BASE. Each word is corrected (single error) or
// flagged (double error), and an 11-bit data value with a 2-bit status is
// written back to DST_BASE. Six cycles per word; done is held until the next
// accepted start.
module secded_mem_decoder #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic [4:0]        single_cnt,
  output logic [4:0]        double_cnt
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, CAP, DEC, WR_LO, WR_HI, DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       cw_lo;
  logic [7:0]       cw_hi;
  logic [7:0]       res_hi_q;

  logic [15:0] cw;
  logic [15:0] fixed;
  logic [3:0]  syn;
  logic        parity;
  logic [1:0]  flag;
  logic [7:0]  res_lo;
  logic [7:0]  res_hi;

  // Byte address of word i in a region; hi selects the upper byte (2i+1).
  function automatic logic [ADDR_W-1:0] word_addr(input int base,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic hi);
    return ADDR_W'(base) + ADDR_W'({i, hi});
  endfunction

  assign cw = {cw_hi, cw_lo};

  // Syndrome, overall parity, correction and result packing for the captured word.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    syn    = '0;
    parity = ^cw;
    fixed  = cw;
    flag   = 2'b00;
    for (int k = 1; k < 16; k++) begin
      if (cw[k]) syn = syn ^ 4'(k);
    end
    if (parity) begin
      // Odd overall parity: one bit is wrong, at position syn (0 means p0).
      fixed[syn] = ~cw[syn];
      flag       = 2'b01;
    end else if (syn != 4'd0) begin
      // Even parity with a non-zero syndrome: two bits wrong, not correctable.
      flag = 2'b10;
    end
    res_lo = {fixed[12:9], fixed[7:5], fixed[3]};
    res_hi = {flag, 3'b000, fixed[15:13]};
  end

  // Sequencer with registered memory interface, status and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      done        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      single_cnt  <= '0;
      double_cnt  <= '0;
      cw_lo       <= '0;
      cw_hi       <= '0;
      res_hi_q    <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the values from before this clock edge.
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RD_LO;
            idx        <= '0;
            done       <= 1'b0;
            single_cnt <= '0;
            double_cnt <= '0;
            mem_addr   <= word_addr(SRC_BASE, '0, 1'b0);
          end
        end
        RD_LO: begin
          mem_addr <= word_addr(SRC_BASE, idx, 1'b1);
          state    <= RD_HI;
        end
        RD_HI: begin
          // Low byte addressed in RD_LO is on the read bus now.
          cw_lo <= mem_rd_data;
          state <= CAP;
        end
        CAP: begin
          cw_hi <= mem_rd_data;
          state <= DEC;
        end
        DEC: begin
          if (flag == 2'b01 && single_cnt != 5'd31) single_cnt <= single_cnt + 5'd1;
          if (flag == 2'b10 && double_cnt != 5'd31) double_cnt <= double_cnt + 5'd1;
          res_hi_q    <= res_hi;
          mem_wr_data <= res_lo;
          mem_addr    <= word_addr(DST_BASE, idx, 1'b0);
          mem_wr_en   <= 1'b1;
          state       <= WR_LO;
        end
        WR_LO: begin
          mem_wr_data <= res_hi_q;
          mem_addr    <= word_addr(DST_BASE, idx, 1'b1);
          state       <= WR_HI;
        end
        WR_HI: begin
          mem_wr_en <= 1'b0;
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx      <= idx + 1'b1;
            mem_addr <= word_addr(SRC_BASE, idx + 1'b1, 1'b0);
            state    <= RD_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secded_mem_decoder.sv
// Self-checking bench for secded_mem_decoder: directed codewords, randomized
// runs with injected 0/1/2-bit errors, done hold, restart and mid-run reset.
module tb_secded_mem_decoder;

  localparam int N   = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [4:0] single_cnt;
  logic [4:0] double_cnt;

  secded_mem_decoder #(
    .NUM_WORDS(N), .SRC_BASE(SRC), .DST_BASE(DST), .ADDR_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .single_cnt(single_cnt), .double_cnt(double_cnt)
  );

  always #5 clk = ~clk;

  // Byte memory with a bench-side load port and write/out-of-range counters.
  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  int         wr_count = 0;
  int         bad_wr = 0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) begin
      wr_count <= wr_count + 1;
      if (int'(mem_addr) >= DST + 2 * N) bad_wr <= bad_wr + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  logic [15:0] src_w [N];
  logic [7:0]  exp_hi [N];
  logic [7:0]  exp_lo [N];
  int          exp_single;
  int          exp_double;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder: data bits fill non-power-of-two positions 3..15 in
  // order; parity bits make the index-XOR of set bits zero; p0 makes it even.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int j;
    int s;
    c = '0;
    j = 0;
    s = 0;
    for (int p = 3; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int p = 1; p < 16; p++) if (c[p]) s = s ^ p;
    for (int k = 0; k < 4; k++) if (s[k]) c[1 << k] = 1'b1;
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    int j;
    d = '0;
    j = 0;
    for (int p = 3; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p];
        j++;
      end
    end
    return d;
  endfunction

  // Expected results follow from what was injected, not from decoding.
  task automatic build_random();
    logic [10:0] data;
    logic [15:0] c;
    int nflip;
    int b1;
    int b2;
    exp_single = 0;
    exp_double = 0;
    for (int i = 0; i < N; i++) begin
      data  = 11'($urandom_range(0, 2047));
      c     = encode(data);
      nflip = int'($urandom_range(0, 2));
      b1    = int'($urandom_range(0, 15));
      b2    = int'($urandom_range(0, 15));
      while (b2 == b1) b2 = int'($urandom_range(0, 15));
      if (nflip >= 1) c[b1] = ~c[b1];
      if (nflip == 2) c[b2] = ~c[b2];
      src_w[i] = c;
      if (nflip == 2) begin
        data = extract(c);
        exp_double++;
        exp_hi[i] = {2'b10, 3'b000, data[10:8]};
      end else if (nflip == 1) begin
        exp_single++;
        exp_hi[i] = {2'b01, 3'b000, data[10:8]};
      end else begin
        exp_hi[i] = {2'b00, 3'b000, data[10:8]};
      end
      exp_lo[i] = data[7:0];
    end
  endtask

  task automatic put_byte(input int a, input logic [7:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = 8'(a);
    ld_data = d;
  endtask

  // Loads source words and pre-fills the destination with a marker value.
  task automatic load_mem();
    for (int i = 0; i < N; i++) begin
      put_byte(SRC + 2 * i,     src_w[i][7:0]);
      put_byte(SRC + 2 * i + 1, src_w[i][15:8]);
      put_byte(DST + 2 * i,     8'hAA);
      put_byte(DST + 2 * i + 1, 8'hAA);
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Pulses start for one cycle; returns at the negedge after the sampling edge.
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full run: latency, per-word results, counters, write count and range.
  task automatic run_and_check(input string name);
    int cyc;
    int w0;
    int b0;
    w0 = wr_count;
    b0 = bad_wr;
    launch();
    cyc = 1;
    check({name, "_start_clears_done"}, 32'(done), 32'd0);
    check({name, "_start_clears_cnts"}, 32'({single_cnt, double_cnt}), 32'd0);
    while (!done && cyc < 300) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check({name, "_latency"}, 32'(cyc), 32'd91);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_w%0d_lo", name, i), 32'(mem[DST + 2 * i]), 32'(exp_lo[i]));
      check($sformatf("%s_w%0d_hi", name, i), 32'(mem[DST + 2 * i + 1]), 32'(exp_hi[i]));
    end
    check({name, "_single_cnt"}, 32'(single_cnt), 32'(exp_single));
    check({name, "_double_cnt"}, 32'(double_cnt), 32'(exp_double));
    check({name, "_wr_count"}, 32'(wr_count - w0), 32'd30);
    check({name, "_wr_out_of_range"}, 32'(bad_wr - b0), 32'd0);
  endtask

  initial begin
    int low_seen;
    int w_snap;
    logic [4:0] s_snap;
    logic [4:0] d_snap;

    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wr_data", 32'(mem_wr_data), 32'd0);
    check("rst_cnts", 32'({single_cnt, double_cnt}), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed codewords from the decode rules.
    for (int i = 0; i < N; i++) begin
      src_w[i]  = 16'h0000;
      exp_hi[i] = 8'h00;
      exp_lo[i] = 8'h00;
    end
    src_w[1] = 16'h0020; exp_hi[1] = 8'h40; exp_lo[1] = 8'h00;
    src_w[2] = 16'h0028; exp_hi[2] = 8'h80; exp_lo[2] = 8'h03;
    src_w[3] = 16'hFFFF; exp_hi[3] = 8'h07; exp_lo[3] = 8'hFF;
    src_w[4] = 16'hFFFE; exp_hi[4] = 8'h47; exp_lo[4] = 8'hFF;
    exp_single = 2;
    exp_double = 1;
    load_mem();
    run_and_check("dir");

    // done and counters hold while idle in DONE.
    low_seen = 0;
    s_snap = single_cnt;
    d_snap = double_cnt;
    repeat (12) begin
      @(negedge clk);
      if (!done) low_seen++;
    end
    check("done_hold", 32'(low_seen), 32'd0);
    check("cnt_hold", 32'({single_cnt, double_cnt}), 32'({s_snap, d_snap}));

    // Randomized runs, each restarted from DONE.
    for (int r = 0; r < 3; r++) begin
      build_random();
      load_mem();
      run_and_check($sformatf("rnd%0d", r));
    end

    // Reset in the middle of a run.
    build_random();
    load_mem();
    launch();
    repeat (39) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_wr_en", 32'(mem_wr_en), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    check("midrst_wr_data", 32'(mem_wr_data), 32'd0);
    check("midrst_cnts", 32'({single_cnt, double_cnt}), 32'd0);
    @(negedge clk);
    w_snap = wr_count;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_writes", 32'(wr_count - w_snap), 32'd0);
    check("midrst_idle_done", 32'(done), 32'd0);

    // Clean run after the reset.
    build_random();
    load_mem();
    run_and_check("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/secded_mem_decoder.md
Name: secded_mem_decoder

Overview:
- Memory-walking Hamming SECDED decoder engine; hardware counterpart of the program-2 decode stage.
- On start, reads NUM_WORDS 16-bit codewords (two bytes each) from byte-wide data memory at SRC_BASE.
- Corrects single-bit errors and flags double-bit errors.
- Writes 11-bit data plus 2-bit status back to DST_BASE, then raises done.

Parameters:
- NUM_WORDS, 15, number of codewords processed per run.
- SRC_BASE, 30, byte address of first codeword low byte.
- DST_BASE, 0, byte address of first result low byte.
- ADDR_W, 8, memory address width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle launch pulse, sampled in IDLE/DONE only.
- done  output  1  run complete; held high until next accepted start or reset.
- mem_addr  output  ADDR_W  byte address for read or write.
- mem_rd_data  input  8  synchronous read data; valid the cycle after mem_addr is presented.
- mem_wr_en  output  1  write strobe; memory writes mem_wr_data at mem_addr on the clk edge.
- mem_wr_data  output  8  write data.
- single_cnt  output  5  count of corrected single errors this run.
- double_cnt  output  5  count of detected double errors this run.

Behaviour:
- Reset (async, reset low): state IDLE, index 0, done 0, mem_wr_en 0, mem_addr 0, mem_wr_data 0, both counters 0.
- Codeword layout, bit index = Hamming position: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}. Source high byte at SRC_BASE+2i+1, low byte at SRC_BASE+2i.
- Syndrome s[3:0] = XOR of the indices of all set bits 1..15. Overall parity P = XOR of all 16 bits.
- Classification:
  - P=0, s=0: no error, flag 00.
  - P=1: single error at position s (s=0 means p0). Flip that bit, flag 01.
  - P=0, s!=0: double error, flag 10, data left uncorrected.
- Result: high byte {flag[1:0], 3'b000, d11:d9}, low byte d8:d1, at DST_BASE+2i+1 / DST_BASE+2i.
- FSM, 6 cycles per word:
  - IDLE: wait for start.
  - RD_LO: addr = src lo.
  - RD_HI: addr = src hi; capture lo.
  - CAP: capture hi.
  - DEC: register result and flag; bump single_cnt or double_cnt.
  - WR_LO: wr_en=1, lo byte to DST_BASE+2i.
  - WR_HI: wr_en=1, hi byte to DST_BASE+2i+1.
  - After WR_HI: if i==NUM_WORDS-1 go to DONE, else i+1 and go to RD_LO.
  - DONE: done=1.
- Latency: start at cycle 0 gives done high at cycle 6*NUM_WORDS+1 (91 for defaults).
- mem_wr_en is high only in WR_LO/WR_HI and never overlaps a read address.
- start in DONE: clears done and both counters, index 0, goes to RD_LO. start while busy is ignored.
- Counters saturate at 31.
- reset mid-run: immediate return to IDLE. Partially written results are left as-is and no write is in progress after reset.
- Overlapping source/destination regions are not supported. Each word's source is read before its destination is written, but no other overlap checks are made.

Test Plan:
- All-zero data, codeword 0x0000 at 30/31 → dest bytes 0x00 / 0x00, single_cnt 0, done at cycle 91.
- Codeword 0x0020 (bit 5 flipped from 0) → result 0x4000, single_cnt 1.
- Codeword 0x0028 (bits 3 and 5 flipped) → hi 0x80, lo 0x03 uncorrected, double_cnt 1.
- Codeword 0xFFFF (data 0x7FF, clean) → hi 0x07, lo 0xFF. Codeword 0xFFFE (p0 flipped) → hi 0x47, lo 0xFF, counted single.
- Full 15-word run with random data and mixed 0/1/2-bit flips; compare against reference model.
  - Check: mem_wr_en asserted exactly 30 times.
  - Check: done stays high until the next start.
  - Check: second start clears both counters.
- Assert reset low at cycle 40 → outputs return to reset values asynchronously, no further writes. Next start performs a clean full run.
